tree_ensemble_sequencer: RTL and testbench
==========================================

Name: tree_ensemble_sequencer

Overview:
- Sits directly downstream of the single-tree traversal engine and wraps it.
- Once a feature vector is loaded, it launches the engine once per tree in the ensemble and selects each tree's node bank via tree_sel.
- Collects each returned signed leaf value into an accumulator.
- Presents the final ensemble score and a thresholded class bit on a valid/ready output port.

Parameters:
- N_TREES, 16, maximum number of trees in the ensemble; tree_sel width is $clog2(N_TREES), minimum 1.
- ACC_W, 32, accumulator and out_sum width (signed); must be >= 32.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  feature vector loaded; request an inference.
- in_ready  output  1  sequencer idle; accepts a request.
- n_trees_cfg  input  $clog2(N_TREES)+1  number of trees to run; sampled on accept.
- threshold  input  ACC_W  signed decision threshold; sampled on accept.
- tree_start  output  1  one-cycle start pulse to the traversal engine.
- tree_sel  output  $clog2(N_TREES)  index of the tree/node bank currently being evaluated.
- tree_done  input  1  engine finished; tree_leaf is valid this cycle.
- tree_leaf  input  32  signed leaf value from the engine.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  signed sum of leaf values.
- out_class  output  1  1 when out_sum >= threshold (signed compare).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: in_ready=1, tree_start=0, tree_sel=0, out_valid=0, out_sum=0, out_class=0, busy=0; accumulator=0; state=IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. An in-flight engine done is ignored afterwards, because WAIT is not active.
- States: IDLE, LAUNCH, WAIT, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch n_trees = min(n_trees_cfg, N_TREES) and threshold; clear accumulator; set tree_sel=0.
  - If n_trees==0, go to RESULT with sum 0. Otherwise go to LAUNCH.
- LAUNCH:
  - tree_start=1 for exactly this cycle; tree_sel stable.
  - Next state is WAIT.
- WAIT:
  - Hold tree_sel; tree_start=0.
  - On tree_done: acc <= acc + sign-extended tree_leaf.
  - If tree_sel==n_trees-1, go to RESULT. Otherwise tree_sel++ and go to LAUNCH.
  - No timeout; WAIT holds indefinitely.
- RESULT:
  - out_valid=1; out_sum=acc; out_class=(acc >= threshold), registered on entry.
  - All three are held stable until out_ready.
  - On out_valid&&out_ready: out_valid drops next cycle; state returns to IDLE; tree_sel returns to 0.
  - in_ready goes high in the cycle after the handshake; there is no same-cycle re-accept.
- tree_done outside WAIT is ignored.
- tree_done in the same cycle as the LAUNCH pulse is not possible by engine contract and is ignored.
- Latency per tree: 1 LAUNCH cycle + engine latency + 1 accumulate cycle.
- Total latency from accept to out_valid = sum over trees of (engine cycles + 2), + 1 cycle.
- in_valid while busy: no accept, no effect. Changes to n_trees_cfg or threshold while busy: no effect.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: each addition saturates to the signed ACC_W range. Overflow clamps to 2^(ACC_W-1)-1; underflow clamps to -2^(ACC_W-1). Once saturated, a later opposite-sign leaf moves the accumulator off the clamp normally.
- Undefined: two's-complement wrap-around addition.

Test Plan:
- Single tree: n_trees_cfg=1, threshold=0, engine returns leaf=5 → exactly one tree_start with tree_sel=0; then out_valid with out_sum=5, out_class=1.
- Four trees: n_trees_cfg=4, leaves {10,-3,7,-20}, threshold=-5 → tree_sel goes 0,1,2,3 in order; out_sum=-6, out_class=0; out_valid held 3 cycles with out_ready low; values unchanged.
- Zero trees and clamping:
  - n_trees_cfg=0 → no tree_start; out_sum=0; out_class=(0>=threshold).
  - n_trees_cfg=N_TREES+1 → exactly N_TREES launches.
- Overflow: ACC_W=32, two leaves of 0x7FFFFFFF:
  - With ACC_SATURATE_EN → out_sum=0x7FFFFFFF.
  - Without ACC_SATURATE_EN → out_sum=0xFFFFFFFE (-2).
- Spurious and back-to-back traffic:
  - tree_done pulsed while in IDLE and in RESULT → accumulator and state unchanged.
  - in_valid held high continuously → second accept occurs one cycle after the output handshake.
- Reset mid-WAIT on tree 2 of 4 → all outputs return to reset values; a later tree_done is ignored; a new request runs cleanly from tree_sel=0.

Source files
------------

// File: rtl/tree_ensemble_sequencer.sv
`default_nettype none
// tree_ensemble_sequencer: runs the traversal engine once per tree, sums signed leaves, thresholds the score. Rev 1.0
// Optional feature macro ACC_SATURATE_EN: saturating accumulation instead of two's-complement wrap.
module tree_ensemble_sequencer #(
  parameter int N_TREES = 16,
  parameter int ACC_W   = 32,
  localparam int SEL_W  = (N_TREES > 1) ? $clog2(N_TREES) : 1,
  localparam int CFG_W  = $clog2(N_TREES) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CFG_W-1:0]        n_trees_cfg,
  input  logic signed [ACC_W-1:0] threshold,
  output logic                    tree_start,
  output logic [SEL_W-1:0]        tree_sel,
  input  logic                    tree_done,
  input  logic signed [31:0]      tree_leaf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_class,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESULT} state_t;

  localparam logic signed [ACC_W-1:0] C_ZERO    = '0;
  localparam logic signed [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  r_state;
  logic [CFG_W-1:0]        r_n_trees;
  logic signed [ACC_W-1:0] r_threshold;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_in_ready;
  logic                    r_tree_start;
  logic [SEL_W-1:0]        r_tree_sel;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_sum;
  logic                    r_out_class;
  logic                    r_busy;

  logic [CFG_W-1:0]        w_n_clamp;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_acc_next;

  assign w_n_clamp = (n_trees_cfg > CFG_W'(N_TREES)) ? CFG_W'(N_TREES) : n_trees_cfg;
  assign w_last    = (CFG_W'(r_tree_sel) == (r_n_trees - CFG_W'(1)));

`ifdef ACC_SATURATE_EN
  logic signed [ACC_W:0] w_sum;
  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign w_sum = $signed({r_acc[ACC_W-1], r_acc}) + (ACC_W+1)'($signed(tree_leaf));

  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_acc_next = w_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX;
    end
  end
`else
  assign w_acc_next = r_acc + ACC_W'($signed(tree_leaf));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_n_trees    <= '0;
      r_threshold  <= '0;
      r_acc        <= '0;
      r_in_ready   <= 1'b1;
      r_tree_start <= 1'b0;
      r_tree_sel   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sum    <= '0;
      r_out_class  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_tree_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_n_trees   <= w_n_clamp;
            r_threshold <= threshold;
            r_acc       <= '0;
            r_tree_sel  <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            if (w_n_clamp == '0) begin
              r_state     <= S_RESULT;
              r_out_valid <= 1'b1;
              r_out_sum   <= '0;
              r_out_class <= (C_ZERO >= threshold);
            end else begin
              r_state      <= S_LAUNCH;
              r_tree_start <= 1'b1;
            end
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (tree_done) begin
            r_acc <= w_acc_next;
            if (w_last) begin
              r_state     <= S_RESULT;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_acc_next;
              r_out_class <= (w_acc_next >= r_threshold);
            end else begin
              r_tree_sel   <= r_tree_sel + SEL_W'(1);
              r_state      <= S_LAUNCH;
              r_tree_start <= 1'b1;
            end
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_tree_sel  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign tree_start = r_tree_start;
  assign tree_sel   = r_tree_sel;
  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign out_class  = r_out_class;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tree_ensemble_sequencer.sv
`default_nettype none
// Bench for tree_ensemble_sequencer: behavioural sum model, engine responder, per-cycle compare.
module tb_tree_ensemble_sequencer;
  localparam int N_TREES = 16;
  localparam int ACC_W   = 32;
  localparam int SEL_W   = 4;
  localparam int CFG_W   = 5;
  localparam int TMO     = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic eng_done = 1'b0;
  logic spur_done = 1'b0;
  logic [CFG_W-1:0] n_trees_cfg = '0;
  logic signed [ACC_W-1:0] threshold = '0;
  logic signed [31:0] eng_leaf = '0;
  logic tree_done;
  logic signed [31:0] tree_leaf;
  logic in_ready, tree_start, out_valid, out_class, busy;
  logic [SEL_W-1:0] tree_sel;
  logic signed [ACC_W-1:0] out_sum;

  assign tree_done = eng_done | spur_done;
  assign tree_leaf = spur_done ? 32'sd999 : eng_leaf;

  tree_ensemble_sequencer #(.N_TREES(N_TREES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .n_trees_cfg(n_trees_cfg), .threshold(threshold), .tree_start(tree_start),
    .tree_sel(tree_sel), .tree_done(tree_done), .tree_leaf(tree_leaf),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_class(out_class), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int leaves_q[$];
  int eng_lat = 1;
  int eng_idx = 0;
  int launch_cnt = 0;
  int exp_n = 0;
  logic signed [31:0] exp_sum = '0;
  logic exp_class = 1'b0;
  logic prev_start = 1'b0;
  logic signed [31:0] got_sum = '0;
  logic got_class = 1'b0;

  function automatic void chk(string name, longint act, longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // Reference: plain integer sum of the first n leaves, wrapped or clamped per add.
  function automatic logic signed [31:0] model_sum(int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      acc += leaves_q[i];
`ifdef ACC_SATURATE_EN
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
      acc = longint'($signed(acc[31:0]));
`endif
    end
    return acc[31:0];
  endfunction

  task automatic set_model(int ncfg, int thr);
    exp_n      = (ncfg > N_TREES) ? N_TREES : ncfg;
    exp_sum    = model_sum(exp_n);
    exp_class  = (exp_sum >= thr);
    launch_cnt = 0;
  endtask

  // Engine stand-in: answers each start pulse after eng_lat cycles with the leaf of that tree.
  always begin
    @(negedge clk);
    if (tree_start && rst_n) begin
      eng_idx = int'(tree_sel);
      repeat (eng_lat) @(posedge clk);
      #1;
      eng_done = 1'b1;
      eng_leaf = (eng_idx < leaves_q.size()) ? leaves_q[eng_idx] : 0;
      @(posedge clk);
      #1 eng_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_ready", longint'(busy), longint'(!in_ready));
      if (tree_start) begin
        chk("tree_sel_order", longint'(tree_sel), launch_cnt);
        chk("start_single_cycle", longint'(prev_start), 0);
        launch_cnt++;
      end
      if (out_valid) begin
        chk("out_sum_model", longint'(out_sum), longint'(exp_sum));
        chk("out_class_model", longint'(out_class), longint'(exp_class));
      end
      prev_start = tree_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < TMO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TMO) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int k = 0;
    while (!out_valid && k < TMO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TMO) chk("out_valid_timeout", 0, 1);
    got_sum   = out_sum;
    got_class = out_class;
  endtask

  task automatic do_accept(int ncfg, int thr);
    wait_ready();
    n_trees_cfg = CFG_W'(ncfg);
    threshold   = thr;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_trees_cfg = 5'd3;
    threshold   = 32'sh7fff0000;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_req(int ncfg, int thr, int lat, int hold, bit spur);
    eng_lat = lat;
    set_model(ncfg, thr);
    do_accept(ncfg, thr);
    @(negedge clk);
    wait_out_valid();
    if (spur) begin
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
    end
    repeat (hold) @(negedge clk);
    chk("out_valid_held", longint'(out_valid), 1);
    handshake();
    @(negedge clk);
    chk("out_valid_drop", longint'(out_valid), 0);
    chk("in_ready_after_hs", longint'(in_ready), 1);
    chk("launch_count", launch_cnt, exp_n);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    chk({tag, "_tree_start"}, longint'(tree_start), 0);
    chk({tag, "_tree_sel"}, longint'(tree_sel), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_sum"}, longint'(out_sum), 0);
    chk({tag, "_out_class"}, longint'(out_class), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    leaves_q = '{5};
    run_req(1, 0, 3, 0, 1'b0);
    chk("single_sum", longint'(got_sum), 5);
    chk("single_class", longint'(got_class), 1);

    leaves_q = '{10, -3, 7, -20};
    chk("model_pin_four", longint'(model_sum(4)), -6);
    run_req(4, -5, 2, 3, 1'b1);
    chk("four_sum", longint'(got_sum), -6);
    chk("four_class", longint'(got_class), 0);

    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", longint'(busy), 0);
    chk("spur_idle_ready", longint'(in_ready), 1);

    run_req(0, 0, 1, 1, 1'b0);
    chk("zero_sum", longint'(got_sum), 0);
    chk("zero_class_thr0", longint'(got_class), 1);
    run_req(0, 1, 1, 0, 1'b0);
    chk("zero_class_thr1", longint'(got_class), 0);

    leaves_q.delete();
    for (int i = 1; i <= N_TREES + 1; i++) leaves_q.push_back(i);
    run_req(N_TREES + 1, 100, 1, 0, 1'b0);
    chk("clamp_launches", launch_cnt, 16);
    chk("clamp_sum", longint'(got_sum), 136);

    leaves_q = '{32'h7FFFFFFF, 32'h7FFFFFFF};
    run_req(2, 0, 1, 0, 1'b0);
`ifdef ACC_SATURATE_EN
    chk("overflow_sum", longint'(got_sum), 64'sd2147483647);
`else
    chk("overflow_sum", longint'(got_sum), -2);
`endif

    leaves_q = '{2, 3};
    eng_lat = 2;
    set_model(2, 5);
    wait_ready();
    n_trees_cfg = 5'd2;
    threshold   = 5;
    in_valid    = 1'b1;
    @(negedge clk);
    wait_out_valid();
    chk("b2b_first_sum", longint'(got_sum), 5);
    handshake();
    set_model(2, 5);
    @(negedge clk);
    chk("b2b_idle_gap", longint'(in_ready), 1);
    @(negedge clk);
    chk("b2b_reaccept", longint'(tree_start), 1);
    in_valid = 1'b0;
    wait_out_valid();
    chk("b2b_second_class", longint'(got_class), 1);
    handshake();
    @(negedge clk);
    chk("b2b_launches", launch_cnt, 2);

    leaves_q = '{1, 2, 3, 4};
    eng_lat = 6;
    set_model(4, 0);
    do_accept(4, 0);
    begin
      int k = 0;
      while (launch_cnt < 2 && k < TMO) begin
        @(negedge clk);
        k++;
      end
      if (k >= TMO) chk("reset_wait_timeout", 0, 1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("late_done_busy", longint'(busy), 0);
    chk("late_done_valid", longint'(out_valid), 0);
    chk("late_done_sel", longint'(tree_sel), 0);
    run_req(4, 10, 1, 0, 1'b0);
    chk("after_abort_sum", longint'(got_sum), 10);
    chk("after_abort_class", longint'(got_class), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
